// File: rtl/snitch_icache_tag_flush.sv
// Instruction-cache tag store: one single-port SRAM per way, cleared by an init walk after reset
// and by a flush walk on request. Define SNITCH_ICACHE_TAG_PARITY_EN for a per-entry even-parity bit.

module snitch_icache_tag_flush_sram #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned WIDTH = 22,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Read port only updates on reads, so the last read data is held across writes and walks.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

module snitch_icache_tag_flush #(
  parameter int unsigned SET_COUNT  = 2,
  parameter int unsigned LINE_COUNT = 128,
  parameter int unsigned TAG_WIDTH  = 20,
  localparam int unsigned ADDR_WIDTH = $clog2(LINE_COUNT),
  localparam int unsigned EW         = TAG_WIDTH + 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_valid_i,
  output logic                          flush_ready_o,
  output logic                          busy_o,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_write_i,
  input  logic [ADDR_WIDTH-1:0]         req_addr_i,
  input  logic [SET_COUNT-1:0]          req_way_mask_i,
  input  logic [SET_COUNT-1:0][EW-1:0]  req_wtag_i,
  output logic                          rsp_valid_o,
  output logic [SET_COUNT-1:0][EW-1:0]  rsp_rtag_o,
  output logic [SET_COUNT-1:0]          rsp_parity_err_o
);
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
  localparam int unsigned SW = EW + 1;
`else
  localparam int unsigned SW = EW;
`endif
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LINE_COUNT - 1);

  typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [SET_COUNT-1:0]    ram_en;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic                    walk;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    busy_o        = 1'b0;
    flush_ready_o = 1'b0;
    req_ready_o   = 1'b0;
    ram_en        = '0;
    ram_we        = 1'b0;
    ram_addr      = req_addr_i;
    walk          = 1'b0;
    unique case (state_q)
      INIT, FLUSH: begin
        busy_o   = 1'b1;
        walk     = 1'b1;
        ram_en   = '1;
        ram_we   = 1'b1;
        ram_addr = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      IDLE: begin
        flush_ready_o = 1'b1;
        req_ready_o   = ~flush_valid_i;
        if (flush_valid_i) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else if (req_valid_i) begin
          ram_we = req_write_i;
          ram_en = req_write_i ? req_way_mask_i : '1;
          rsp_valid_d = ~req_write_i;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;

  for (genvar i = 0; i < SET_COUNT; i++) begin : g_way
    logic [EW-1:0] entry;
    logic [SW-1:0] wdata, rdata;

    assign entry = walk ? '0 : req_wtag_i[i];
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
    assign wdata = {^entry, entry};
    // Stored parity makes the whole word XOR to zero; only valid entries are flagged.
    assign rsp_parity_err_o[i] = rsp_valid_q & rdata[EW-1] & (^rdata);
`else
    assign wdata = entry;
    assign rsp_parity_err_o[i] = 1'b0;
`endif
    assign rsp_rtag_o[i] = rdata[EW-1:0];

    snitch_icache_tag_flush_sram #(
      .DEPTH (LINE_COUNT),
      .WIDTH (SW)
    ) u_sram (
      .clk_i   (clk_i),
      .en_i    (ram_en[i]),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (wdata),
      .rdata_o (rdata)
    );
  end
endmodule

// File: tb/tb_snitch_icache_tag_flush.sv
// Scoreboard bench for snitch_icache_tag_flush: reads push expected entries, a monitor pops them
// on rsp_valid_o and checks timing, data and parity flags.

module tb_snitch_icache_tag_flush;
  localparam int SC = 2;
  localparam int LC = 128;
  localparam int TW = 20;
  localparam int EW = TW + 2;
  localparam int AW = 7;

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic                   flush_valid_i, flush_ready_o, busy_o;
  logic                   req_valid_i, req_ready_o, req_write_i;
  logic [AW-1:0]          req_addr_i;
  logic [SC-1:0]          req_way_mask_i;
  logic [SC-1:0][EW-1:0]  req_wtag_i;
  logic                   rsp_valid_o;
  logic [SC-1:0][EW-1:0]  rsp_rtag_o;
  logic [SC-1:0]          rsp_parity_err_o;

  always #5 clk = ~clk;

  snitch_icache_tag_flush #(.SET_COUNT(SC), .LINE_COUNT(LC), .TAG_WIDTH(TW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o), .busy_o(busy_o),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_way_mask_i(req_way_mask_i), .req_wtag_i(req_wtag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rtag_o(rsp_rtag_o), .rsp_parity_err_o(rsp_parity_err_o)
  );

  typedef struct {
    int                    cyc;
    logic [SC-1:0][EW-1:0] tag;
    logic [SC-1:0]         perr;
  } exp_t;

  exp_t          sb[$];
  logic [EW-1:0] model [SC][LC];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc_cnt = 0;
  bit            model_idle = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Response monitor: each expected entry must show up exactly in its cycle.
  always @(negedge clk) begin
    if (rst_ni === 1'b1) begin
      if (rsp_valid_o === 1'b1) begin
        vectors++;
        if (sb.size() == 0 || sb[0].cyc != cyc_cnt) begin
          miscompares++;
          $display("FAIL unexpected_rsp cyc=%0d rtag=%h queued=%0d", cyc_cnt, rsp_rtag_o, sb.size());
        end else begin
          if (rsp_rtag_o !== sb[0].tag || rsp_parity_err_o !== sb[0].perr) begin
            miscompares++;
            $display("FAIL rsp_data cyc=%0d got tag=%h perr=%b want tag=%h perr=%b",
                     cyc_cnt, rsp_rtag_o, rsp_parity_err_o, sb[0].tag, sb[0].perr);
          end
          void'(sb.pop_front());
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc_cnt) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_rsp cyc=%0d want tag=%h", cyc_cnt, sb[0].tag);
        void'(sb.pop_front());
      end
    end
  end

  task automatic idle_in();
    flush_valid_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0;
    req_addr_i = '0; req_way_mask_i = '0; req_wtag_i = '0;
  endtask

  task automatic clear_model();
    for (int w = 0; w < SC; w++) for (int l = 0; l < LC; l++) model[w][l] = '0;
  endtask

  task automatic rd(input int a, input logic [SC-1:0] pe = '0);
    exp_t e;
    @(posedge clk); #1;
    idle_in();
    req_valid_i = 1'b1; req_addr_i = AW'(a);
    if (model_idle) begin
      e.cyc = cyc_cnt + 1;
      for (int w = 0; w < SC; w++) e.tag[w] = model[w][a];
      e.perr = pe;
      sb.push_back(e);
    end
  endtask

  task automatic wr(input int a, input logic [SC-1:0] m, input logic [EW-1:0] w0, input logic [EW-1:0] w1);
    @(posedge clk); #1;
    idle_in();
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = AW'(a);
    req_way_mask_i = m; req_wtag_i[0] = w0; req_wtag_i[1] = w1;
    if (model_idle) begin
      if (m[0]) model[0][a] = w0;
      if (m[1]) model[1][a] = w1;
    end
  endtask

  task automatic settle(input int n);
    @(posedge clk); #1;
    idle_in();
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_walk(output int n);
    n = 0;
    while (busy_o === 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    model_idle = (busy_o === 1'b0);
  endtask

  task automatic test_reset();
    int n;
    idle_in();
    rst_ni = 1'b0;
    #1;
    vectors++;
    if ({busy_o, flush_ready_o, req_ready_o, rsp_valid_o, rsp_parity_err_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b fr=%b rr=%b rv=%b pe=%b want 1 0 0 0 00",
               busy_o, flush_ready_o, req_ready_o, rsp_valid_o, rsp_parity_err_o);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    clear_model(); model_idle = 1'b0;
    wait_walk(n);
    vectors++;
    if (n !== 128) begin miscompares++; $display("FAIL init_walk_len got %0d want 128", n); end
    vectors++;
    if (flush_ready_o !== 1'b1 || req_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_ready got fr=%b rr=%b want 1 1", flush_ready_o, req_ready_o);
    end
    rd(127);
    settle(2);
  endtask

  task automatic test_write_read();
    logic [EW-1:0] e0;
    e0 = {1'b1, 1'b0, 20'hABCDE};
    wr(5, 2'b01, e0, EW'($urandom));
    #1;
    vectors++;
    if (req_ready_o !== 1'b1) begin miscompares++; $display("FAIL write_ready got %b want 1", req_ready_o); end
    rd(5);
    wr(6, 2'b00, EW'($urandom), EW'($urandom));
    rd(6);
    wr(7, 2'b10, EW'($urandom), {1'b1, 1'b1, 20'h12345});
    rd(7);
    rd(5);
    settle(2);
  endtask

  task automatic test_flush();
    int n;
    logic [SC-1:0][EW-1:0] held;
    wr(5, 2'b11, {1'b1, 1'b0, 20'h55555}, {1'b1, 1'b0, 20'hAAAAA});
    rd(5);
    held[0] = model[0][5]; held[1] = model[1][5];
    @(posedge clk); #1;
    idle_in();
    flush_valid_i = 1'b1; req_valid_i = 1'b1; req_addr_i = AW'(5);
    #1;
    vectors++;
    if (flush_ready_o !== 1'b1 || req_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_priority got fr=%b rr=%b want 1 0", flush_ready_o, req_ready_o);
    end
    @(posedge clk); #1;
    idle_in();
    clear_model(); model_idle = 1'b0;
    wait_walk(n);
    vectors++;
    if (n !== 128) begin miscompares++; $display("FAIL flush_walk_len got %0d want 128", n); end
    vectors++;
    if (rsp_rtag_o !== held) begin
      miscompares++;
      $display("FAIL hold_over_flush got %h want %h", rsp_rtag_o, held);
    end
    rd(5);
    settle(2);
  endtask

  task automatic test_back_to_back();
    logic [SC-1:0][EW-1:0] l3;
    for (int l = 1; l <= 3; l++) wr(l, 2'b11, {2'b10, TW'($urandom)}, {2'b11, TW'($urandom)});
    l3[0] = model[0][3]; l3[1] = model[1][3];
    rd(1); rd(2); rd(3);
    wr(3, 2'b11, EW'($urandom), EW'($urandom));
    settle(3);
    vectors++;
    if (rsp_rtag_o !== l3) begin
      miscompares++;
      $display("FAIL hold_after_b2b got %h want %h", rsp_rtag_o, l3);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    @(posedge clk); #1;
    idle_in(); flush_valid_i = 1'b1;
    @(posedge clk); #1;
    idle_in(); clear_model(); model_idle = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    rst_ni = 1'b0; sb.delete();
    #1;
    vectors++;
    if (busy_o !== 1'b1 || flush_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midwalk_reset got busy=%b fr=%b want 1 0", busy_o, flush_ready_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    wait_walk(n);
    vectors++;
    if (n !== 128) begin miscompares++; $display("FAIL restart_walk_len got %0d want 128", n); end
    wr(1, 2'b11, {1'b1, 1'b0, 20'hF00F0}, {1'b1, 1'b0, 20'h0F00F});
    rd(1);
    @(posedge clk); #1;
    idle_in();
    rst_ni = 1'b0; sb.delete();
    #1;
    vectors++;
    if (rsp_valid_o !== 1'b0) begin miscompares++; $display("FAIL midread_reset rv got %b want 0", rsp_valid_o); end
    @(posedge clk); #1;
    rst_ni = 1'b1;
    clear_model(); model_idle = 1'b0;
    wait_walk(n);
    vectors++;
    if (n !== 128) begin miscompares++; $display("FAIL reset_after_read_walk got %0d want 128", n); end
    rd(1);
    settle(2);
  endtask

`ifdef SNITCH_ICACHE_TAG_PARITY_EN
  task automatic test_parity();
    wr(9, 2'b11, {1'b1, 1'b0, 20'h13579}, {1'b1, 1'b0, 20'h2468A});
    rd(9);
    settle(1);
    dut.g_way[1].u_sram.mem_q[9] = dut.g_way[1].u_sram.mem_q[9] ^ 23'd1;
    model[1][9] = model[1][9] ^ 22'd1;
    rd(9, 2'b10);
    settle(2);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_flush();
    test_back_to_back();
    test_mid_reset();
`ifdef SNITCH_ICACHE_TAG_PARITY_EN
    test_parity();
`endif
    settle(2);
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL drain got %0d pending want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/snitch_icache_tag_flush.md
SNITCH_ICACHE_TAG_FLUSH -- requirements
Module: snitch_icache_tag_flush

Interface
REQ-001 SHALL have parameter SET_COUNT, default 2, number of tag ways.
REQ-002 SHALL have parameter LINE_COUNT, default 128, lines per way, power of two, >= 2.
REQ-003 SHALL have parameter TAG_WIDTH, default 20, tag bits excluding status bits.
REQ-004 SHALL derive ADDR_WIDTH = $clog2(LINE_COUNT) and entry width EW = TAG_WIDTH+2, laid out as {valid, err, tag}.
REQ-005 SHALL have one clock, clk_i; reset is asynchronous and active-low, rst_ni.
REQ-006 clk_i  in  1  clock.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 flush_valid_i  in  1  flush request.
REQ-009 flush_ready_o  out  1  flush accepted.
REQ-010 busy_o  out  1  init or flush walk in progress.
REQ-011 req_valid_i  in  1  access request.
REQ-012 req_ready_o  out  1  access accepted.
REQ-013 req_write_i  in  1  1 = write, 0 = read.
REQ-014 req_addr_i  in  ADDR_WIDTH  line index.
REQ-015 req_way_mask_i  in  SET_COUNT  per-way write enable, ignored on reads.
REQ-016 req_wtag_i  in  SET_COUNT x EW  write entries.
REQ-017 rsp_valid_o  out  1  read data valid.
REQ-018 rsp_rtag_o  out  SET_COUNT x EW  read entries, all ways.
REQ-019 rsp_parity_err_o  out  SET_COUNT  per-way parity error.

Function
REQ-020 SHALL implement FSM states INIT, IDLE, FLUSH.
REQ-021 INIT/FLUSH SHALL write entry 0 to all ways at walk counter address, one line per cycle, counter 0 -> LINE_COUNT-1.
REQ-022 After writing line LINE_COUNT-1, the FSM SHALL move to IDLE on the next edge; each walk takes exactly LINE_COUNT cycles.
REQ-023 busy_o SHALL be 1 in INIT and FLUSH and 0 in IDLE.
REQ-024 flush_ready_o SHALL be 1 only in IDLE; a handshake SHALL move the FSM to FLUSH with counter 0.
REQ-025 req_ready_o SHALL be 1 only in IDLE with flush_valid_i = 0; flush SHALL win over a simultaneous request.
REQ-026 An accepted write SHALL update only the ways whose req_way_mask_i bit is 1; mask 0 SHALL be a no-op that is still accepted.
REQ-027 An accepted read SHALL enable all ways; rsp_valid_o SHALL be 1 exactly one cycle later, for one cycle.
REQ-028 rsp_rtag_o SHALL hold the last read data until the next read response, including across writes and flushes.
REQ-029 A read accepted in the cycle before a flush handshake SHALL still produce its response.
REQ-030 Writes and walks SHALL never assert rsp_valid_o.
REQ-031 Back-to-back reads SHALL sustain one per cycle.
REQ-032 Storage SHALL be one single-port, 1-cycle-latency SRAM per way, LINE_COUNT deep.

Reset
REQ-033 On rst_ni low, state SHALL become INIT, counter 0, rsp_valid_o 0, busy_o 1, flush_ready_o 0, req_ready_o 0, rsp_parity_err_o 0.
REQ-034 Reset asserted mid-walk or mid-read SHALL abort it and restart INIT from line 0; SRAM contents are not reset, and the walk clears them.

Configuration
REQ-035 With macro SNITCH_ICACHE_TAG_PARITY_EN defined, each way SHALL store EW+1 bits, with an even-parity bit over the entry computed on write.
REQ-036 With the macro defined, rsp_parity_err_o[i] SHALL be 1 with rsp_valid_o when stored parity mismatches and the valid bit is 1; all-zero walk entries SHALL check clean.
REQ-037 Without the macro, storage width SHALL be EW and rsp_parity_err_o SHALL be constant 0.

Verification
REQ-038 Release reset, SET_COUNT=2, LINE_COUNT=128 -> busy_o 1 for 128 cycles, then IDLE; a read of line 127 returns 0 in both ways.
REQ-039 Write line 5 with mask 2'b01 and way0 entry {1,0,0xABCDE}, then read line 5 -> next cycle rsp_valid_o 1, way0 = {1,0,0xABCDE}, way1 = 0.
REQ-040 flush_valid_i and req_valid_i raised in the same IDLE cycle -> flush accepted, request not; 128 busy cycles follow; a later read of line 5 returns 0.
REQ-041 Reads of lines 1, 2, 3 on consecutive cycles -> three consecutive rsp_valid_o pulses in order; rsp_rtag_o holds line-3 data afterwards.
REQ-042 Reset pulsed at walk count 60 -> walk restarts at 0 and busy_o stays 1 for 128 cycles after release.
REQ-043 With SNITCH_ICACHE_TAG_PARITY_EN, force a bit flip in stored way1 line 9 (valid=1), then read -> rsp_parity_err_o = 2'b10.
